// File: rtl/nmt_mem_arbiter.sv
// nmt_mem_arbiter: round-robin arbiter of N_PORTS NMT devices onto BIGMEM's single port, one transaction at a time.
// Optional macro NMT_ARB_STATS_EN adds stat_grants, per-port saturating 16-bit accepted-request counters.
module nmt_mem_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DW      = 32,
  parameter int CW      = 2
) (
  input  logic                  clk_t,
  input  logic                  rst_n,
  input  logic [N_PORTS-1:0]    req_valid,
  output logic [N_PORTS-1:0]    req_ready,
  input  logic [N_PORTS*DW-1:0] req_alu,
  input  logic [N_PORTS*DW-1:0] req_reg2,
  input  logic [N_PORTS*CW-1:0] req_cmd,
  output logic [N_PORTS-1:0]    rsp_valid,
  input  logic [N_PORTS-1:0]    rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [DW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DW-1:0]         mem_rdata
`ifdef NMT_ARB_STATS_EN
  ,
  output logic [N_PORTS*16-1:0] stat_grants
`endif
);

  localparam int GW = $clog2(N_PORTS);
  localparam logic [CW-1:0] CMD_NOP   = CW'(0);
  localparam logic [CW-1:0] CMD_STORE = CW'(2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_next;
  logic [GW-1:0] r_last, w_gnt, w_idx;
  logic          w_hit, w_accept, w_hs, w_rd;
  logic [CW-1:0] r_cmd, w_cmd;
  logic [DW-1:0] r_addr, r_wdata, r_data;

  // Round-robin search starting just after the last granted port
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      w_idx = GW'((int'(r_last) + k) % N_PORTS);
      if (!w_hit && req_valid[w_idx]) begin
        w_hit = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_cmd    = req_cmd[int'(w_gnt)*CW +: CW];
  assign w_accept = (r_state == S_IDLE) && w_hit && rst_n;
  assign w_hs     = (r_state == S_ISSUE) && mem_ready;
  assign w_rd     = (r_cmd != CMD_STORE);

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          req_ready[w_gnt] = 1'b1;
          w_next = (w_cmd == CMD_NOP) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = !w_rd;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        // Read data arriving in the handshake cycle skips WAIT
        if (mem_ready) w_next = (!w_rd || mem_rvalid) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid[r_last] = 1'b1;
        rsp_data          = r_data;
        if (rsp_ready[r_last]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_t) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_last  <= GW'(N_PORTS - 1);
    end else begin
      r_state <= w_next;
      if (w_accept) r_last <= w_gnt;
    end
  end

  // Request payload and response data; outputs are gated by state, so no reset needed
  always_ff @(posedge clk_t) begin
    if (w_accept) begin
      r_addr  <= req_alu[int'(w_gnt)*DW +: DW];
      r_wdata <= req_reg2[int'(w_gnt)*DW +: DW];
      r_cmd   <= w_cmd;
      r_data  <= '0;
    end else if (mem_rvalid && w_rd && (w_hs || (r_state == S_WAIT))) begin
      r_data <= mem_rdata;
    end
  end

`ifdef NMT_ARB_STATS_EN
  logic [15:0] r_stat [N_PORTS];

  always_ff @(posedge clk_t) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PORTS; i++) r_stat[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++)
        if (req_ready[i] && (r_stat[i] != 16'hFFFF)) r_stat[i] <= r_stat[i] + 16'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_PORTS; i++) stat_grants[i*16 +: 16] = r_stat[i];
  end
`endif

endmodule

// File: tb/tb_nmt_mem_arbiter.sv
// Testbench for nmt_mem_arbiter: vector table, directed corner sequences and a randomized run
// checked against a transaction-level reference model.
module tb_nmt_mem_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  logic              clk_t;
  logic              rst_n;
  logic [NP-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NP*DW-1:0]  req_alu, req_reg2;
  logic [NP*CW-1:0]  req_cmd;
  logic [DW-1:0]     rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic              mem_valid, mem_ready, mem_we, mem_rvalid;
`ifdef NMT_ARB_STATS_EN
  logic [NP*16-1:0]  stat_grants;
`endif

  nmt_mem_arbiter #(.N_PORTS(NP), .DW(DW), .CW(CW)) dut (
    .clk_t(clk_t), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu(req_alu), .req_reg2(req_reg2), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef NMT_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  initial clk_t = 1'b0;
  always #5 clk_t = ~clk_t;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [NP-1:0] valid;
    logic [NP-1:0] exp_ready;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_t);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int p, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    req_cmd[p*CW +: CW]  = c;
    req_alu[p*DW +: DW]  = a;
    req_reg2[p*DW +: DW] = d;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req_ready"}, 32'(req_ready), 0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({nm, "_rsp_data"},  rsp_data, 0);
    chk({nm, "_mem_valid"}, 32'(mem_valid), 0);
    chk({nm, "_mem_we"},    32'(mem_we), 0);
    chk({nm, "_mem_addr"},  mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; req_alu = '0; req_reg2 = '0; req_cmd = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    settle();
    chk_zero("reset");
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int rr_pick(input logic [NP-1:0] v, input int last);
    for (int k = 1; k <= NP; k++)
      if (v[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  // Reference model state for the randomized run
  int            p_st [NP];
  logic [1:0]    p_cmd [NP];
  logic [31:0]   p_addr [NP], p_wd [NP];
  int            m_ph, m_port, m_last, r_cnt, n_done, busy_cyc, g, d;
  logic [1:0]    m_cmd;
  logic [31:0]   m_addr, m_wd, m_exp;
  logic [NP-1:0] exp_rdy, exp_rsp;
  logic          fire, hs, hs_rd;

  initial begin
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b0001, 4'b0001};
    tbl[3] = '{4'b1001, 4'b1000};
    tbl[4] = '{4'b0110, 4'b0010};
    tbl[5] = '{4'b0100, 4'b0100};
    tbl[6] = '{4'b0011, 4'b0001};
    tbl[7] = '{4'b1000, 4'b1000};
    tbl[8] = '{4'b1010, 4'b0010};

    do_reset();
    for (int v = 0; v < 9; v++) begin
      req_valid = tbl[v].valid; req_cmd = '0; rsp_ready = 4'hF;
      settle();
      chk($sformatf("tbl%0d_grant", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      chk($sformatf("tbl%0d_memv", v), 32'(mem_valid), 0);
      step();
      req_valid = '0;
      settle();
      chk($sformatf("tbl%0d_rsp", v), 32'(rsp_valid), 32'(tbl[v].exp_ready));
      chk($sformatf("tbl%0d_data", v), rsp_data, 0);
      step();
    end

    // Continuous requests from all ports: one grant every two cycles in order 0,1,2,3,0,1
    do_reset();
    req_valid = 4'hF; req_cmd = '0; rsp_ready = 4'hF;
    for (int c = 0; c < 12; c++) begin
      settle();
      exp_rdy = (c % 2 == 0) ? 4'(1 << ((c / 2) % NP)) : 4'b0;
      exp_rsp = (c % 2 == 1) ? 4'(1 << ((c / 2) % NP)) : 4'b0;
      chk($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("rr_rsp_c%0d", c), 32'(rsp_valid), 32'(exp_rsp));
      step();
    end

    // Single LOAD on port 0 with minimum latency
    do_reset();
    req_valid = 4'b0001; set_req(0, 2'b01, 32'h40, 32'h0);
    settle();
    chk("load_accept", 32'(req_ready), 32'h1);
    step();
    req_valid = '0; mem_ready = 1'b1;
    settle();
    chk("load_memv", 32'(mem_valid), 1);
    chk("load_addr", mem_addr, 32'h40);
    chk("load_we", 32'(mem_we), 0);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("load_rsp_early", 32'(rsp_valid), 0);
    step();
    mem_rvalid = 1'b0; rsp_ready = 4'hF;
    settle();
    chk("load_rsp_c3", 32'(rsp_valid), 32'h1);
    chk("load_data", rsp_data, 32'hDEADBEEF);
    step();
    rsp_ready = '0;

    // STORE on port 2 returns a zero ack without waiting for read data
    req_valid = 4'b0100; set_req(2, 2'b10, 32'h10, 32'h12345678);
    settle();
    chk("store_accept", 32'(req_ready), 32'h4);
    step();
    req_valid = '0; mem_ready = 1'b1;
    settle();
    chk("store_memv", 32'(mem_valid), 1);
    chk("store_we", 32'(mem_we), 1);
    chk("store_addr", mem_addr, 32'h10);
    chk("store_wdata", mem_wdata, 32'h12345678);
    step();
    mem_ready = 1'b0; rsp_ready = 4'hF;
    settle();
    chk("store_rsp", 32'(rsp_valid), 32'h4);
    chk("store_data", rsp_data, 0);
    chk("store_nomem", 32'(mem_valid), 0);
    step();
    rsp_ready = '0;

    // Stalled memory, coincident rvalid, stalled response, then reset during WAIT
    req_valid = 4'b0010; set_req(1, 2'b01, 32'h80, 32'h0);
    settle();
    chk("stall_accept", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1010; set_req(3, 2'b01, 32'h100, 32'h0);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("stall_memv_c%0d", c), 32'(mem_valid), 1);
      chk($sformatf("stall_addr_c%0d", c), mem_addr, 32'h80);
      chk($sformatf("stall_noready_c%0d", c), 32'(req_ready), 0);
      step();
    end
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    settle();
    chk("coinc_memv", 32'(mem_valid), 1);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("hold_rsp_c%0d", c), 32'(rsp_valid), 32'h2);
      chk($sformatf("hold_data_c%0d", c), rsp_data, 32'hCAFEF00D);
      chk($sformatf("hold_noready_c%0d", c), 32'(req_ready), 0);
      step();
    end
    rsp_ready = 4'b0010;
    settle();
    chk("exit_rsp", 32'(rsp_valid), 32'h2);
    chk("exit_nogrant", 32'(req_ready), 0);
    step();
    rsp_ready = '0;
    settle();
    chk("next_grant_p3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0; mem_ready = 1'b1;
    settle();
    chk("p3_addr", mem_addr, 32'h100);
    step();
    mem_ready = 1'b0; rst_n = 1'b0;
    settle();
    step();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55555555; rsp_ready = 4'hF;
    settle();
    chk_zero("midreset");
    step();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("late_rvalid_rsp_c%0d", c), 32'(rsp_valid), 0);
      chk($sformatf("late_rvalid_memv_c%0d", c), 32'(mem_valid), 0);
      step();
    end
    req_valid = 4'b1001; req_cmd = '0;
    settle();
    chk("post_reset_prio", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    step();

`ifdef NMT_ARB_STATS_EN
    do_reset();
    rsp_ready = 4'hF; req_cmd = '0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      step();
    end
    settle();
    chk("stat_p0", 32'(stat_grants[0 +: 16]), 0);
    chk("stat_p1", 32'(stat_grants[16 +: 16]), 0);
    chk("stat_p2", 32'(stat_grants[32 +: 16]), 0);
    chk("stat_p3", 32'(stat_grants[48 +: 16]), 3);
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    m_ph = 0; m_last = NP - 1; m_port = 0; r_cnt = 0; n_done = 0; busy_cyc = 0;
    m_cmd = '0; m_addr = '0; m_wd = '0; m_exp = '0;
    for (int i = 0; i < NP; i++) begin
      p_st[i] = 0; p_cmd[i] = '0; p_addr[i] = '0; p_wd[i] = '0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (p_st[i] == 0 && $urandom_range(0, 3) == 0) begin
          p_cmd[i] = 2'($urandom_range(0, 3));
          p_addr[i] = $urandom;
          p_wd[i] = $urandom;
          p_st[i] = 1;
        end
        req_valid[i] = (p_st[i] == 1);
        set_req(i, p_cmd[i], p_addr[i], p_wd[i]);
        rsp_ready[i] = ($urandom_range(0, 2) != 0);
      end
      mem_ready = ($urandom_range(0, 1) == 1);
      fire = 1'b0;
      if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0) fire = 1'b1;
      end
      hs = (m_ph == 1) && mem_ready;
      hs_rd = hs && (m_cmd != 2'b10);
      if (hs_rd) begin
        d = $urandom_range(0, 2);
        if (d == 0) fire = 1'b1;
        else r_cnt = d;
      end
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (fire) begin
        mem_rvalid = 1'b1;
        mem_rdata = memfun(m_addr);
      end else if (r_cnt == 0 && !hs_rd && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;
      end
      settle();

      g = (m_ph == 0) ? rr_pick(req_valid, m_last) : -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      exp_rsp = (m_ph == 3) ? 4'(1 << m_port) : 4'b0;
      chk("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd_mem_valid", 32'(mem_valid), 32'(m_ph == 1));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      if (m_ph == 1) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_we", 32'(mem_we), 32'(m_cmd == 2'b10));
        if (m_cmd == 2'b10) chk("rnd_mem_wdata", mem_wdata, m_wd);
      end
      if (m_ph == 3) chk("rnd_rsp_data", rsp_data, m_exp);

      case (m_ph)
        0: if (g >= 0) begin
          m_port = g; m_last = g; m_cmd = p_cmd[g]; m_addr = p_addr[g]; m_wd = p_wd[g];
          m_exp = '0; p_st[g] = 2;
          m_ph = (p_cmd[g] == 2'b00) ? 3 : 1;
        end
        1: if (mem_ready) begin
          if (m_cmd == 2'b10) m_ph = 3;
          else if (mem_rvalid) begin m_exp = mem_rdata; m_ph = 3; end
          else m_ph = 2;
        end
        2: if (mem_rvalid) begin m_exp = mem_rdata; m_ph = 3; end
        3: if (rsp_ready[m_port]) begin p_st[m_port] = 0; m_ph = 0; n_done++; end
        default: m_ph = 0;
      endcase

      busy_cyc = (m_ph != 0) ? busy_cyc + 1 : 0;
      if (busy_cyc > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rnd_watchdog: transaction open %0d cycles, limit 200", busy_cyc);
        break;
      end
      step();
    end
    chk("rnd_enough_done", 32'(n_done > 100), 1);

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
